stream_burst_drain: RTL and testbench
=====================================

# stream_burst_drain

Drains a show-ahead FIFO (sync or dual-clock, read side) and presents its contents as a valid/rdy stream toward the host DMA engine. Words are released in bursts of BURST_LEN once the FIFO reports it is no longer almost-empty; a partial burst is released on timeout or on an explicit flush. A 2-entry skid buffer on the output keeps `fifo_rd_en` free of any combinational path from `s_rdy`. Sits directly downstream of the stream FIFO in the loopback path, in the FIFO's read-clock domain.

## Interface
- DATA_WIDTH, 128, stream and FIFO word width
- BURST_LEN, 16, words popped per burst (1..256)
- TIMEOUT, 256, idle cycles with a non-empty FIFO before a partial flush; 0 disables the timeout
- CNT_WIDTH, 32, width of `word_count`

- clk  in  1  FIFO read clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- fifo_dout  in  DATA_WIDTH  show-ahead head word, valid while `!fifo_empty`
- fifo_empty  in  1  FIFO empty
- fifo_almostempty  in  1  FIFO at or below its almost-empty threshold
- fifo_rd_en  out  1  pop the FIFO head this cycle
- flush  in  1  level; drain the FIFO completely regardless of burst size
- s_valid  out  1  `s_data` valid
- s_rdy  in  1  consumer accepts the word this cycle
- s_data  out  DATA_WIDTH  output word
- word_count  out  CNT_WIDTH  accepted transfers (`s_valid & s_rdy`); wraps modulo 2^CNT_WIDTH
- busy  out  1  state != IDLE, or the skid buffer is non-empty

## Operation
- FSM states:
  - IDLE: no pops.
  - BURST: pops up to BURST_LEN words.
  - FLUSH: pops until the FIFO is empty.
- IDLE -> FLUSH when `flush`=1. Flush has priority in every state.
- IDLE -> BURST when `!fifo_almostempty`.
- IDLE -> FLUSH when the timer reaches TIMEOUT (TIMEOUT != 0) and `!fifo_empty`.
- BURST -> IDLE when the pop counter reaches BURST_LEN.
- BURST -> FLUSH when `flush`=1. The partial beat count is discarded.
- FLUSH -> IDLE when `fifo_empty`=1 and `flush`=0. With `flush` held high, FLUSH is retained.
- Pop rule: `fifo_rd_en = (state != IDLE) & !fifo_empty & (occ != 2)`.
  - `occ` is the registered skid occupancy, 0..2.
  - No path from `s_rdy` to `fifo_rd_en`.
- Skid buffer: FIFO order preserved. `s_valid = (occ != 0)`. `s_data` = oldest entry.
  - Simultaneous push and pop leaves `occ` unchanged.
- Pop counter: cleared on entry to BURST. Increments on each `fifo_rd_en`; 9-bit.
- Timer:
  - Counts cycles while in IDLE with `!fifo_empty`.
  - Cleared on `fifo_empty` or on leaving IDLE.
  - Saturates at TIMEOUT.
- `word_count` increments on every `s_valid & s_rdy`.
- Reset values:
  - state IDLE, `occ`=0
  - `fifo_rd_en`=0, `s_valid`=0, `s_data`=0
  - `word_count`=0, `busy`=0
  - counters 0
- Reset mid-operation clears everything asynchronously. Skid contents are discarded and lost. The FIFO's own reset is independent.
- `s_data` and `s_valid` must not change while `s_valid & !s_rdy` (stable hold).

## Timing
- FIFO word popped in cycle N is on `s_data` with `s_valid`=1 from cycle N+1.
- `fifo_almostempty` low at edge k: state=BURST from k+1, first `fifo_rd_en` in cycle k+1, first `s_valid` at k+2.
- Sustained throughput is 1 word/cycle with `s_rdy`=1 and a non-empty FIFO.
- After the BURST_LEN-th pop, `fifo_rd_en` is 0 in the following cycle; at least one IDLE cycle separates bursts.
- `s_rdy` deasserted: at most 2 more pops before `fifo_rd_en` drops (`occ` reaches 2). When `s_rdy` returns, pops resume the cycle after `occ` falls below 2.
- Timeout partial flush: first pop TIMEOUT+1 cycles after the FIFO becomes non-empty in IDLE.

## Structure
- Shared package `stream_pkg`:
  - state encoding IDLE=2'd0, BURST=2'd1, FLUSH=2'd2
  - `clogb2` function
  - default DATA_WIDTH
- Sub-module `stream_skid_buffer`: 2-entry registered skid. Ports: clk, rst_n, in_valid, in_data, out_valid, out_rdy, out_data, occ[1:0]. FSM, counters and pop rule stay in the top.

## Test plan
- Preload 16 words (almostempty low), `s_rdy`=1 -> 16 consecutive pops, data 0..15 in order, `s_valid` 16 cycles starting 2 cycles after almostempty falls, then IDLE, `word_count`=16.
- Preload 40 words, `s_rdy`=1 -> bursts of 16, 16 pops, then 8 remain until timeout -> 8 flushed 257 cycles after entering IDLE with almostempty high; `word_count`=40.
- Burst in progress, `s_rdy` low for 10 cycles -> exactly 2 extra pops then `fifo_rd_en`=0, `s_data` stable, no loss or duplication on release.
- `flush` pulse with 3 words and almostempty high -> FLUSH next cycle, 3 pops, `busy` drops after the last transfer.
- `rst_n` low mid-burst with `occ`=2 -> `s_valid`=0, `word_count`=0, `fifo_rd_en`=0 immediately; normal operation after release.
- TIMEOUT=0, 1 word, `flush`=0 -> word never drained.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream drain path: FSM state encoding,
// default word width and a constant-width helper.
package stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    // Number of bits needed to index 0..value-1, never less than one.
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) bits = b + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/stream_burst_drain_if.sv
// Valid/ready stream carrying drained FIFO words toward the host DMA engine.
interface stream_burst_drain_if import stream_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  s_valid;
    logic                  s_rdy;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_rdy);
    modport slave  (input s_valid, input s_data, output s_rdy);
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry registered skid buffer. Words leave in arrival order and the
// head entry never moves while it is offered but not taken, so the output
// is stable under backpressure. The producer must not push when occ is 2.
module stream_skid_buffer import stream_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occ
);
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  take;

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
    assign take      = out_valid & out_rdy;

    // Entry movement and occupancy; a push and a take together keep occ unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({in_valid, take})
                2'b10: begin
                    if (occ == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/stream_burst_drain.sv
// Drains a show-ahead FIFO in bursts of BURST_LEN words once it is no longer
// almost-empty, or completely on flush / idle timeout, and presents the words
// as a valid/ready stream through a skid buffer. The pop decision only looks
// at registered occupancy, so s_rdy never reaches fifo_rd_en combinationally.
module stream_burst_drain import stream_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 16,
    parameter int TIMEOUT    = 256,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_almostempty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    stream_burst_drain_if.master  s,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);
    localparam int                 TIMER_W   = clogb2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);
    localparam logic [8:0]         LAST_POP  = 9'(BURST_LEN - 1);

    drain_state_e       state;
    logic [8:0]         pop_cnt;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         occ;
    logic               timed_out;

    assign fifo_rd_en = (state != IDLE) && !fifo_empty && (occ != 2'd2);
    assign busy       = (state != IDLE) || (occ != 2'd0);
    assign timed_out  = (TIMEOUT != 0) && (timer == TIMER_MAX) && !fifo_empty;

    // Burst/flush sequencing; flush wins in every state, and a burst ends on the edge of its last pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pop_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= FLUSH;
                    end else if (!fifo_almostempty) begin
                        state   <= BURST;
                        pop_cnt <= '0;
                    end else if (timed_out) begin
                        state <= FLUSH;
                    end
                end
                BURST: begin
                    if (fifo_rd_en) pop_cnt <= pop_cnt + 9'd1;
                    if (flush)                                   state <= FLUSH;
                    else if (fifo_rd_en && pop_cnt == LAST_POP)  state <= IDLE;
                end
                FLUSH: begin
                    if (fifo_empty && !flush) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Idle timer: runs while words wait in IDLE, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state != IDLE || fifo_empty) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Count of words accepted by the consumer, wrapping naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (s.s_valid && s.s_rdy) begin
            word_count <= word_count + CNT_WIDTH'(1);
        end
    end

    stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_rd_en),
        .in_data   (fifo_dout),
        .out_valid (s.s_valid),
        .out_rdy   (s.s_rdy),
        .out_data  (s.s_data),
        .occ       (occ)
    );
endmodule

// File: tb/tb_stream_burst_drain.sv
// Bench for stream_burst_drain: a queue-based show-ahead FIFO feeds the DUT,
// accepted words and pop cycles are logged, and each scenario task compares
// the logs against the word order and cycle timing the drain rules imply.
module tb_stream_burst_drain;
    localparam int DW        = 128;
    localparam int BL        = 16;
    localparam int TO        = 256;
    localparam int CW        = 32;
    localparam int ALMOST_TH = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] fifo_dout        = '0;
    logic          fifo_empty       = 1'b1;
    logic          fifo_almostempty = 1'b1;
    logic          fifo_rd_en;
    logic          flush;
    logic [CW-1:0] word_count;
    logic          busy;

    logic [DW-1:0] fifo2_dout = 128'h5a5a;
    logic          fifo2_empty = 1'b0;
    logic          fifo2_ae    = 1'b1;
    logic          flush2      = 1'b0;
    logic          rd_en2;
    logic [CW-1:0] wc2;
    logic          busy2;

    stream_burst_drain_if #(.DATA_WIDTH(DW)) sif ();
    stream_burst_drain_if #(.DATA_WIDTH(DW)) sif2 ();

    stream_burst_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_almostempty(fifo_almostempty), .fifo_rd_en(fifo_rd_en), .flush(flush),
        .s(sif.master), .word_count(word_count), .busy(busy)
    );

    stream_burst_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(0), .CNT_WIDTH(CW)) dut_nto (
        .clk(clk), .rst_n(rst_n), .fifo_dout(fifo2_dout), .fifo_empty(fifo2_empty),
        .fifo_almostempty(fifo2_ae), .fifo_rd_en(rd_en2), .flush(flush2),
        .s(sif2.master), .word_count(wc2), .busy(busy2)
    );

    logic [DW-1:0] load_buf[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] out_q[$];
    int            rd_log[$];
    int            load_rd = 0;
    int            cyc = 0;
    int            n_rd2 = 0;
    int            n_v2 = 0;
    logic          fifo_clear = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            wc_exp = 0;

    // FIFO model and logging: pop/clear/load at the edge, publish head and flags after it.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() > 0) fq.delete(0);
            rd_log.push_back(cyc);
        end
        if (sif.s_valid && sif.s_rdy) out_q.push_back(sif.s_data);
        if (fifo_clear) fq.delete();
        while (load_rd < load_buf.size()) begin
            fq.push_back(load_buf[load_rd]);
            load_rd++;
        end
        fifo_empty       <= (fq.size() == 0);
        fifo_almostempty <= (fq.size() <= ALMOST_TH);
        fifo_dout        <= (fq.size() != 0) ? fq[0] : '0;
        if (rd_en2) n_rd2++;
        if (sif2.s_valid) n_v2++;
        cyc++;
    end

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_seq(input int n);
        for (int i = 0; i < n; i++) load_buf.push_back(DW'(i));
    endtask

    task automatic load_rand(input int n);
        for (int i = 0; i < n; i++) load_buf.push_back(rand_word());
    endtask

    task automatic wait_done(input int target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (out_q.size() >= target && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int rd_at(input int idx);
        return (idx < rd_log.size()) ? rd_log[idx] : -1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (sif.s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b exp 0", sif.s_valid); end
        checks++; if (sif.s_data !== '0) begin errors++; $display("FAIL reset_s_data got %h exp 0", sif.s_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        int ob, rb, lb, c0;
        bit ok;
        ob = out_q.size(); rb = rd_log.size(); lb = load_buf.size();
        sif.s_rdy = 1'b1;
        c0 = cyc;
        load_seq(BL);
        wait_done(ob + BL, 200, ok);
        wc_exp += BL;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_done got %b exp 1", ok); end
        checks++; if (rd_log.size() - rb !== BL) begin errors++; $display("FAIL burst_pops got %0d exp %0d", rd_log.size() - rb, BL); end
        checks++; if (rd_at(rb) !== c0 + 2) begin errors++; $display("FAIL burst_first_pop got %0d exp %0d", rd_at(rb), c0 + 2); end
        checks++; if (rd_at(rb + BL - 1) !== c0 + BL + 1) begin errors++; $display("FAIL burst_last_pop got %0d exp %0d", rd_at(rb + BL - 1), c0 + BL + 1); end
        for (int i = 0; i < BL && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL burst_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_timeout_flush();
        int ob, rb, lb;
        bit ok;
        ob = out_q.size(); rb = rd_log.size(); lb = load_buf.size();
        sif.s_rdy = 1'b1;
        load_rand(40);
        wait_done(ob + 40, 700, ok);
        wc_exp += 40;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done got %b exp 1", ok); end
        checks++; if (rd_log.size() - rb !== 40) begin errors++; $display("FAIL tmo_pops got %0d exp 40", rd_log.size() - rb); end
        checks++; if (rd_at(rb + 16) - rd_at(rb + 15) !== 2) begin errors++; $display("FAIL tmo_burst_gap got %0d exp 2", rd_at(rb + 16) - rd_at(rb + 15)); end
        checks++; if (rd_at(rb + 31) - rd_at(rb + 16) !== 15) begin errors++; $display("FAIL tmo_burst2_span got %0d exp 15", rd_at(rb + 31) - rd_at(rb + 16)); end
        checks++; if (rd_at(rb + 32) - rd_at(rb + 31) !== TO + 2) begin errors++; $display("FAIL tmo_gap got %0d exp %0d", rd_at(rb + 32) - rd_at(rb + 31), TO + 2); end
        for (int i = 0; i < 40 && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL tmo_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL tmo_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_stall();
        int ob, rb, lb, r, unstable;
        logic [DW-1:0] held;
        bit ok;
        ob = out_q.size(); rb = rd_log.size(); lb = load_buf.size();
        sif.s_rdy = 1'b0;
        load_rand(BL);
        repeat (3) @(negedge clk);
        held = sif.s_data;
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sif.s_valid !== 1'b1 || sif.s_data !== held) unstable++;
        end
        checks++; if (rd_log.size() - rb !== 2) begin errors++; $display("FAIL stall_pops got %0d exp 2", rd_log.size() - rb); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_hold got %0d changes exp 0", unstable); end
        checks++; if (held !== load_buf[lb]) begin errors++; $display("FAIL stall_head got %h exp %h", held, load_buf[lb]); end
        r = cyc;
        sif.s_rdy = 1'b1;
        wait_done(ob + BL, 200, ok);
        wc_exp += BL;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", ok); end
        checks++; if (rd_at(rb + 2) !== r + 1) begin errors++; $display("FAIL stall_resume got %0d exp %0d", rd_at(rb + 2), r + 1); end
        checks++; if (rd_log.size() - rb !== BL) begin errors++; $display("FAIL stall_total_pops got %0d exp %0d", rd_log.size() - rb, BL); end
        checks++; if (out_q.size() - ob !== BL) begin errors++; $display("FAIL stall_count got %0d exp %0d", out_q.size() - ob, BL); end
        for (int i = 0; i < BL && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL stall_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_flush();
        int ob, rb, lb, f;
        ob = out_q.size(); rb = rd_log.size(); lb = load_buf.size();
        sif.s_rdy = 1'b1;
        load_rand(3);
        @(negedge clk);
        f = cyc;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_enter got %b exp 1", fifo_rd_en); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_tail got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_drop got %b exp 0", busy); end
        wc_exp += 3;
        checks++; if (rd_log.size() - rb !== 3) begin errors++; $display("FAIL flush_pops got %0d exp 3", rd_log.size() - rb); end
        checks++; if (rd_at(rb) !== f + 1) begin errors++; $display("FAIL flush_first_pop got %0d exp %0d", rd_at(rb), f + 1); end
        checks++; if (rd_at(rb + 2) !== f + 3) begin errors++; $display("FAIL flush_last_pop got %0d exp %0d", rd_at(rb + 2), f + 3); end
        for (int i = 0; i < 3 && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL flush_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL flush_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_reset_mid();
        int ob, rb, lb;
        bit ok;
        rb = rd_log.size();
        sif.s_rdy = 1'b0;
        load_rand(BL);
        repeat (5) @(negedge clk);
        checks++; if (rd_log.size() - rb !== 2) begin errors++; $display("FAIL rstmid_fill got %0d exp 2", rd_log.size() - rb); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sif.s_valid !== 1'b0) begin errors++; $display("FAIL rstmid_s_valid got %b exp 0", sif.s_valid); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL rstmid_word_count got %0d exp 0", word_count); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b exp 0", fifo_rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        fifo_clear = 1'b1;
        @(negedge clk);
        fifo_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wc_exp = 0;
        @(negedge clk);
        ob = out_q.size(); lb = load_buf.size();
        sif.s_rdy = 1'b1;
        load_rand(BL);
        wait_done(ob + BL, 200, ok);
        wc_exp += BL;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b exp 1", ok); end
        for (int i = 0; i < BL && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL rstmid_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_random_backpressure();
        int ob, rb, lb, n, viol;
        bit ok, prev_v, prev_r;
        logic [DW-1:0] prev_d;
        ob = out_q.size(); rb = rd_log.size(); lb = load_buf.size();
        n = $urandom_range(20, 60);
        load_rand(n);
        ok = 1'b0; viol = 0; prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (prev_v && !prev_r && (sif.s_valid !== 1'b1 || sif.s_data !== prev_d)) viol++;
            if (out_q.size() >= ob + n && !busy) begin
                ok = 1'b1;
                break;
            end
            prev_v = sif.s_valid;
            prev_d = sif.s_data;
            prev_r = ($urandom_range(0, 3) != 0);
            sif.s_rdy = prev_r;
        end
        sif.s_rdy = 1'b1;
        wc_exp += n;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_done got %b exp 1", ok); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL rand_hold got %0d changes exp 0", viol); end
        checks++; if (rd_log.size() - rb !== n) begin errors++; $display("FAIL rand_pops got %0d exp %0d", rd_log.size() - rb, n); end
        checks++; if (out_q.size() - ob !== n) begin errors++; $display("FAIL rand_count got %0d exp %0d", out_q.size() - ob, n); end
        for (int i = 0; i < n && ob + i < out_q.size(); i++) begin
            checks++; if (out_q[ob + i] !== load_buf[lb + i]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, out_q[ob + i], load_buf[lb + i]); end
        end
        checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL rand_word_count got %0d exp %0d", word_count, wc_exp); end
    endtask

    task automatic test_no_timeout();
        repeat (300) @(negedge clk);
        checks++; if (n_rd2 !== 0) begin errors++; $display("FAIL nto_pops got %0d exp 0", n_rd2); end
        checks++; if (n_v2 !== 0) begin errors++; $display("FAIL nto_valid_cycles got %0d exp 0", n_v2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL nto_busy got %b exp 0", busy2); end
        checks++; if (wc2 !== '0) begin errors++; $display("FAIL nto_word_count got %0d exp 0", wc2); end
    endtask

    initial begin
        sif.s_rdy  = 1'b1;
        sif2.s_rdy = 1'b1;
        flush      = 1'b0;
        test_reset();
        test_single_burst();
        test_timeout_flush();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random_backpressure();
        test_no_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
